// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction memory and decoder-side signals of the fetch stage
interface inst_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] link_pc;
    logic [5:0]  op_o;
    logic [5:0]  funct_o;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc, link_pc, op_o, funct_o,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc, link_pc, op_o, funct_o,
        output inst_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - registered FIFO of fetched {pc, inst} pairs; flush beats push and pop
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;

    // Empty head reads as a NOP at PC 0 so the decoder never sees stale storage.
    assign head = empty ? '{pc: 32'h0, inst: NOP} : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch PC, one-outstanding imem request FSM, redirect handling, decode field split
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2,
    localparam int         CW       = $clog2(QDEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    inst_fetch_if.master bus,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          discard_q, discard_d;

    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_head;
    fetch_entry_t  q_wdata;
    logic          handshake;

    // Gating with rst_n keeps the request low for the whole reset pulse, not just after an edge.
    assign bus.imem_req  = rst_n && (state_q == S_REQ) && (q_count < CW'(QDEPTH)) && !redirect_valid;
    assign bus.imem_addr = fetch_pc_q;
    assign handshake     = bus.imem_req && bus.imem_ready;

    assign q_wdata = '{pc: fetch_pc_q, inst: bus.imem_rdata};
    assign q_pop   = bus.inst_valid && bus.inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        q_push     = 1'b0;
        case (state_q)
            S_REQ: begin
                if (handshake) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d   = S_REQ;
                    discard_d = 1'b0;
                    if (!discard_q && !redirect_valid && !q_full) begin
                        q_push     = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end
            default: state_d = S_REQ;
        endcase
        // A redirect overrides the PC and poisons whatever response is still owed to us.
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            if ((state_q == S_REQ && handshake) || (state_q == S_WAIT && !bus.imem_rvalid)) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign bus.inst_valid = !q_empty;
    assign bus.inst       = q_head.inst;
    assign bus.inst_pc    = q_head.pc;
    assign bus.link_pc    = q_head.pc + 32'd4;
    assign bus.op_o       = q_head.inst[31:26];
    assign bus.funct_o    = q_head.inst[5:0];

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with directed scenarios and a random program-order model
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    bit ready_rand = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'h2008_0005 ^ (a * 32'h9E37_79B1);
    endfunction

    // Memory: accepts on req&&ready, answers mem_lat cycles later (0 = random 1..3), forgets on reset.
    initial begin : mem_model
        bit          pend;
        int          pend_wait;
        logic [31:0] pend_addr;
        pend = 1'b0;
        pend_wait = 0;
        pend_addr = '0;
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else if (bus.imem_req && bus.imem_ready) begin
                pend      = 1'b1;
                pend_addr = bus.imem_addr;
                pend_wait = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
            end
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (pend && rst_n) begin
                if (pend_wait <= 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_fn(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            bus.imem_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus.inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus.inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== RPC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RPC); end
        n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
        n_checks++; if (bus.inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
        n_checks++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", bus.inst_pc); end
        n_checks++; if (bus.link_pc !== 32'h4) begin n_fail++; $display("FAIL reset_link_pc: got %h want 4", bus.link_pc); end
        n_checks++; if (bus.op_o !== 6'h0 || bus.funct_o !== 6'h0) begin n_fail++; $display("FAIL reset_fields: got op %h funct %h want 0 0", bus.op_o, bus.funct_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin n_fail++; $display("FAIL release_req: got req %b addr %h want 1 %h", bus.imem_req, bus.imem_addr, RPC); end
    endtask

    task automatic test_first_fetch;
        bit seen = 1'b0;
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL first_valid: got none want inst_valid within 10 cycles"); end
        n_checks++; if (bus.inst !== 32'h2008_0005) begin n_fail++; $display("FAIL first_inst: got %h want 20080005", bus.inst); end
        n_checks++; if (bus.op_o !== 6'h08 || bus.funct_o !== 6'h05) begin n_fail++; $display("FAIL first_fields: got op %h funct %h want 08 05", bus.op_o, bus.funct_o); end
        n_checks++; if (bus.inst_pc !== 32'h0 || bus.link_pc !== 32'h4) begin n_fail++; $display("FAIL first_pc: got pc %h link %h want 0 4", bus.inst_pc, bus.link_pc); end
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL second_req: got req %b addr %h want 1 4", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_fill;
        int reqs = 0;
        int hs = 0;
        do_reset();
        mem_lat = 1;
        repeat (12) tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) reqs++;
        end
        n_checks++; if (reqs != 0) begin n_fail++; $display("FAIL fill_req_idle: got %0d requests want 0", reqs); end
        n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL fill_head: got valid %b pc %h want 1 0", bus.inst_valid, bus.inst_pc); end
        tick();
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * QD)) begin n_fail++; $display("FAIL refill_req: got req %b addr %h want 1 %h", bus.imem_req, bus.imem_addr, 32'(4 * QD)); end
        n_checks++; if (bus.inst_pc !== 32'h4) begin n_fail++; $display("FAIL refill_head: got pc %h want 4", bus.inst_pc); end
        if (bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) hs++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) hs++;
        end
        n_checks++; if (hs != 1) begin n_fail++; $display("FAIL refill_count: got %0d handshakes want 1", hs); end
    endtask

    task automatic test_redirect_wait;
        bit found = 1'b0;
        bit stale = 1'b0;
        bit got_hs = 1'b0;
        bit got_valid = 1'b0;
        logic [31:0] hs_addr = '0;
        logic [31:0] v_pc = '0;
        logic [31:0] v_inst = '0;
        do_reset();
        mem_lat = 3;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rdw_hs: got none want handshake"); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rdw_req_blocked: got %b want 0", bus.imem_req); end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_flush: got %b want 0", bus.inst_valid); end
        for (int i = 0; i < 30; i++) begin
            if (i != 0) @(negedge clk);
            if (bus.inst_valid === 1'b1 && bus.inst_pc === 32'h0) stale = 1'b1;
            if (!got_hs && bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) begin got_hs = 1'b1; hs_addr = bus.imem_addr; end
            if (!got_valid && bus.inst_valid === 1'b1) begin got_valid = 1'b1; v_pc = bus.inst_pc; v_inst = bus.inst; end
        end
        n_checks++; if (stale) begin n_fail++; $display("FAIL rdw_stale: got stale pc 0 instruction want none"); end
        n_checks++; if (!got_hs || hs_addr !== 32'h100) begin n_fail++; $display("FAIL rdw_target: got seen %b addr %h want 1 00000100", got_hs, hs_addr); end
        n_checks++; if (!got_valid || v_pc !== 32'h100 || v_inst !== mem_fn(32'h100)) begin n_fail++; $display("FAIL rdw_head: got seen %b pc %h inst %h want 1 00000100 %h", got_valid, v_pc, v_inst, mem_fn(32'h100)); end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_redirect_rvalid;
        bit found = 1'b0;
        bit seen = 1'b0;
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1 && bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rdr_setup: got none want handshake with queue non-empty"); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2000;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.imem_rvalid !== 1'b1 || bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL rdr_coincide: got rvalid %b valid %b want 1 1", bus.imem_rvalid, bus.inst_valid); end
        tick();
        redirect_valid = 1'b0;
        bus.inst_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_empty: got %b want 0", bus.inst_valid); end
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h2000) begin n_fail++; $display("FAIL rdr_target: got req %b addr %h want 1 00002000", bus.imem_req, bus.imem_addr); end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen || bus.inst_pc !== 32'h2000) begin n_fail++; $display("FAIL rdr_head: got seen %b pc %h want 1 00002000", seen, bus.inst_pc); end
    endtask

    task automatic test_wrap;
        int nhs = 0;
        logic [31:0] a0 = '0;
        logic [31:0] a1 = '0;
        bit got_valid = 1'b0;
        logic [31:0] v_pc = '0;
        logic [31:0] v_link = '0;
        do_reset();
        mem_lat = 1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_req_blocked: got %b want 0", bus.imem_req); end
        tick();
        redirect_valid = 1'b0;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) begin
                if (nhs == 0) a0 = bus.imem_addr;
                if (nhs == 1) a1 = bus.imem_addr;
                nhs++;
            end
            if (!got_valid && bus.inst_valid === 1'b1) begin got_valid = 1'b1; v_pc = bus.inst_pc; v_link = bus.link_pc; end
        end
        n_checks++; if (nhs < 2 || a0 !== 32'hFFFF_FFFC || a1 !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got n %0d %h %h want >=2 fffffffc 00000000", nhs, a0, a1); end
        n_checks++; if (!got_valid || v_pc !== 32'hFFFF_FFFC || v_link !== 32'h0) begin n_fail++; $display("FAIL wrap_link: got seen %b pc %h link %h want 1 fffffffc 00000000", got_valid, v_pc, v_link); end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        bit found = 1'b0;
        bit seen = 1'b0;
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1 && bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL arst_setup: got none want S_WAIT with one entry"); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_immediate: got valid %b req %b want 0 0", bus.inst_valid, bus.imem_req); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin n_fail++; $display("FAIL arst_resume: got req %b addr %h want 1 %h", bus.imem_req, bus.imem_addr, RPC); end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen || bus.inst_pc !== RPC || bus.inst !== mem_fn(RPC)) begin n_fail++; $display("FAIL arst_head: got seen %b pc %h inst %h want 1 %h %h", seen, bus.inst_pc, bus.inst, RPC, mem_fn(RPC)); end
    endtask

    // Program-order model: each redirect restarts a sequential stream; a response owed across a redirect is void.
    task automatic test_random;
        logic [31:0] mq[$];
        logic [31:0] next_fetch;
        logic [31:0] if_addr = '0;
        bit inflight = 1'b0;
        bit stale = 1'b0;
        do_reset();
        mem_lat = 0;
        ready_rand = 1'b1;
        next_fetch = RPC;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.inst_ready = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            @(negedge clk);
            n_checks++; if (bus.inst_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, bus.inst_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_checks++; if (bus.inst_pc !== mq[0] || bus.link_pc !== mq[0] + 32'd4) begin n_fail++; $display("FAIL rnd_pc @%0d: got %h/%h want %h/%h", cyc, bus.inst_pc, bus.link_pc, mq[0], mq[0] + 32'd4); end
                n_checks++; if (bus.inst !== mem_fn(mq[0]) || bus.op_o !== mem_fn(mq[0]) >> 26 || bus.funct_o !== 6'(mem_fn(mq[0]))) begin n_fail++; $display("FAIL rnd_inst @%0d: got %h op %h funct %h want %h", cyc, bus.inst, bus.op_o, bus.funct_o, mem_fn(mq[0])); end
            end else begin
                n_checks++; if (bus.inst !== NOP || bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL rnd_empty @%0d: got inst %h pc %h want 0 0", cyc, bus.inst, bus.inst_pc); end
            end
            if (mq.size() == QD || redirect_valid) begin
                n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_req_block @%0d: got %b want 0 (occupancy %0d)", cyc, bus.imem_req, mq.size()); end
            end
            if (bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) begin
                n_checks++; if (bus.imem_addr !== next_fetch || inflight) begin n_fail++; $display("FAIL rnd_req_addr @%0d: got %h inflight %b want %h 0", cyc, bus.imem_addr, inflight, next_fetch); end
                inflight = 1'b1;
                stale = 1'b0;
                if_addr = bus.imem_addr;
            end
            if (redirect_valid) begin
                mq.delete();
                next_fetch = redirect_pc & 32'hFFFF_FFFC;
                if (bus.imem_rvalid === 1'b1) inflight = 1'b0;
                else if (inflight) stale = 1'b1;
            end else begin
                if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1 && mq.size() != 0) void'(mq.pop_front());
                if (bus.imem_rvalid === 1'b1) begin
                    if (!stale) begin
                        mq.push_back(if_addr);
                        next_fetch = if_addr + 32'd4;
                    end
                    inflight = 1'b0;
                    stale = 1'b0;
                end
            end
            tick();
        end
        ready_rand = 1'b0;
        redirect_valid = 1'b0;
        bus.inst_ready = 1'b0;
        mem_lat = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus.inst_ready = 1'b0;
        test_reset();
        test_first_fetch();
        test_fill();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
